trans_traffic_checker: RTL and testbench
========================================

// Module: trans_traffic_checker
// PURPOSE
//  Synthesizable, parametrised traffic generator and self-checker for the transaction layer.
//  Sequence: configure the FSM thresholds, push a deterministic word set into every FIFO in,
//  drain every FIFO out while checking destination and checksum, then read the word counters
//  via req/idx. Replaces hand-written push/pop sequences; scales to any port count.
// PARAMETERS
//  NUM_PORTS      4   number of FIFO in and FIFO out ports (>=2, power of 2)
//  WORD_SIZE      10  FIFO word width = {dest, payload}
//  DEST_BITS      $clog2(NUM_PORTS)  dest field width, MSBs of the word
//  WORDS_PER_PORT 8   words pushed per FIFO in (1..2**CNT_SIZE-1)
//  PTR_SIZE       3   threshold width (FIFO_PTR_SIZE)
//  CNT_SIZE       5   counter data width
//  TIMEOUT        255 cycles allowed per wait phase before failing
// PORTS
//  clk               in  1                  clock, all logic on posedge
//  reset_L           in  1                  synchronous active-low reset
//  start             in  1                  1-cycle pulse in IDLE starts a run
//  ae_thr / af_thr   in  PTR_SIZE each      thresholds forwarded during CONFIG
//  init              out 1                  to FSM, high only in CONFIG
//  almost_empty_threshold_input out PTR_SIZE  registered copy of ae_thr
//  almost_full_threshold_input  out PTR_SIZE  registered copy of af_thr
//  push_FIFO_in      out NUM_PORTS          per-port push
//  dest_n_data_in    out NUM_PORTS*WORD_SIZE  port p at [p*WORD_SIZE +: WORD_SIZE]
//  almost_full_in    in  NUM_PORTS          FIFO in almost-full flags
//  pop_FIFO_out      out NUM_PORTS          per-port pop
//  data_out          in  NUM_PORTS*WORD_SIZE  FIFO out data, same packing
//  empty_out         in  NUM_PORTS          FIFO out empty flags
//  idle              in  1                  FSM idle
//  req / idx         out 1 / DEST_BITS      counter request and index
//  data / valid      in  CNT_SIZE / 1       counter response
//  done / pass       out 1 / 1              run finished / finished with no error
//  err_flags         out NUM_PORTS+2        [p]=port p data/count error, [N]=timeout, [N+1]=unused, 0
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, all counters, checksums and err_flags cleared.
//  FSM: IDLE -start-> CONFIG (4 cycles, init=1, thresholds registered on first cycle)
//   -> SEND -all ports sent WORDS_PER_PORT-> DRAIN -idle & all empty_out for 2 consecutive
//   cycles, no pop in flight-> COUNT -> DONE. Any phase timeout -> DONE with err_flags[N]=1.
//   DONE holds done=1 until start (re-run, clears flags) or reset. start outside IDLE/DONE ignored.
//  Word k (0..WORDS_PER_PORT-1) from port p: dest=(p+k) mod NUM_PORTS,
//   payload=(p*WORDS_PER_PORT+k) mod 2**(WORD_SIZE-DEST_BITS). Each FIFO out therefore
//   receives exactly WORDS_PER_PORT words.
//  SEND: port p pushes word k in a cycle iff almost_full_in[p]==0 and k<WORDS_PER_PORT;
//   k increments on push. Ports are independent; finished ports hold push low.
//   Timeout counter restarts on any push.
//  DRAIN: pop_FIFO_out[p]=!empty_out[p]; data_out sampled the cycle after the pop. Per port:
//   received count++, checksum += payload (mod 2**payload width), dest field!=p sets err_flags[p].
//   Timeout counter restarts on any pop.
//  COUNT: for i=0..NUM_PORTS-1: req=1 idx=i, held until valid=1 (TIMEOUT limit), then 1 cycle
//   req=0 before the next index. data!=received[i] or received[i]!=WORDS_PER_PORT or
//   checksum mismatch against expected sum sets err_flags[i].
//  pass = done & (err_flags==0). Reset mid-run aborts immediately to IDLE, outputs 0 next cycle.
// TESTING
//  Ideal model, N=4, W=8: start -> 8 pushes/port in 8 cycles, 8 words/out port,
//   counter reads 8,8,8,8 -> done=1 pass=1.
//  almost_full_in[2] held 1 for 20 cycles in SEND -> no push on port 2 in that window,
//   run completes, pass=1.
//  Model flips dest of one word to port 0 that belongs to port 3 -> err_flags[3], err_flags[0] set, pass=0.
//  Counter model returns 7 for idx=1 -> err_flags[1]=1 only, pass=0.
//  valid never asserted -> done after TIMEOUT cycles in COUNT, err_flags[4]=1.
//  reset_L=0 for 1 cycle mid-SEND -> all outputs 0 next cycle, restart gives pass=1.

Source files
------------

// File: rtl/trans_traffic_checker.sv
// Traffic generator and self-checker for the transaction layer: configures the FSM,
// pushes a deterministic word set into every FIFO in, drains and checks every FIFO out.
module trans_traffic_checker #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned WORD_SIZE      = 10,
    parameter int unsigned DEST_BITS      = $clog2(NUM_PORTS),
    parameter int unsigned WORDS_PER_PORT = 8,
    parameter int unsigned PTR_SIZE       = 3,
    parameter int unsigned CNT_SIZE       = 5,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic                           clk,
    input  logic                           reset_L,
    input  logic                           start,
    input  logic [PTR_SIZE-1:0]            ae_thr,
    input  logic [PTR_SIZE-1:0]            af_thr,
    output logic                           init,
    output logic [PTR_SIZE-1:0]            almost_empty_threshold_input,
    output logic [PTR_SIZE-1:0]            almost_full_threshold_input,
    output logic [NUM_PORTS-1:0]           push_FIFO_in,
    output logic [NUM_PORTS*WORD_SIZE-1:0] dest_n_data_in,
    input  logic [NUM_PORTS-1:0]           almost_full_in,
    output logic [NUM_PORTS-1:0]           pop_FIFO_out,
    input  logic [NUM_PORTS*WORD_SIZE-1:0] data_out,
    input  logic [NUM_PORTS-1:0]           empty_out,
    input  logic                           idle,
    output logic                           req,
    output logic [DEST_BITS-1:0]           idx,
    input  logic [CNT_SIZE-1:0]            data,
    input  logic                           valid,
    output logic                           done,
    output logic                           pass,
    output logic [NUM_PORTS+1:0]           err_flags
);
    localparam int unsigned PAY_BITS = WORD_SIZE - DEST_BITS;
    localparam int unsigned TMO_BITS = $clog2(TIMEOUT + 1);
    localparam logic [CNT_SIZE-1:0]  WPP      = CNT_SIZE'(WORDS_PER_PORT);
    localparam logic [TMO_BITS-1:0]  TMO_LAST = TMO_BITS'(TIMEOUT - 1);
    localparam logic [DEST_BITS-1:0] LAST_IDX = DEST_BITS'(NUM_PORTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_SEND,
        S_DRAIN,
        S_COUNT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]           cfg_cnt;
    logic [CNT_SIZE-1:0]  sent [NUM_PORTS];
    logic [CNT_SIZE-1:0]  rcvd [NUM_PORTS];
    logic [PAY_BITS-1:0]  csum [NUM_PORTS];
    logic [PAY_BITS-1:0]  exp_sum [NUM_PORTS];
    logic [NUM_PORTS-1:0] pop_q;
    logic [TMO_BITS-1:0]  tmo_cnt;
    logic                 quiet_prev;
    logic                 cnt_gap;
    logic [DEST_BITS-1:0] idx_q;
    logic [NUM_PORTS:0]   err_q;
    logic [PTR_SIZE-1:0]  ae_q, af_q;

    logic run_start, progress, all_sent, quiet_now, tmo_hit;

    // Sum of all payloads addressed to out port q, wrapped to the payload width.
    function automatic logic [PAY_BITS-1:0] expected_sum(input int unsigned q);
        logic [PAY_BITS-1:0] s;
        s = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++)
            for (int unsigned k = 0; k < WORDS_PER_PORT; k++)
                if ((p + k) % NUM_PORTS == q)
                    s = s + PAY_BITS'(p * WORDS_PER_PORT + k);
        return s;
    endfunction

    for (genvar q = 0; q < NUM_PORTS; q++) begin : g_exp
        localparam logic [PAY_BITS-1:0] SUM = expected_sum(q);
        assign exp_sum[q] = SUM;
    end

    assign run_start = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset_L) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        init           = 1'b0;
        push_FIFO_in   = '0;
        dest_n_data_in = '0;
        pop_FIFO_out   = '0;
        req            = 1'b0;
        idx            = '0;
        done           = 1'b0;
        progress       = 1'b0;
        tmo_hit        = 1'b0;
        all_sent       = 1'b1;
        quiet_now      = idle && (&empty_out) && (pop_q == '0);

        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (sent[p] != WPP)
                all_sent = 1'b0;
            if (state == S_SEND && !almost_full_in[p] && sent[p] < WPP) begin
                push_FIFO_in[p] = 1'b1;
                dest_n_data_in[p*WORD_SIZE +: WORD_SIZE] =
                    {DEST_BITS'(p + 32'(sent[p])), PAY_BITS'(p * WORDS_PER_PORT + 32'(sent[p]))};
            end
        end

        case (state)
            S_IDLE: begin
                if (start) state_nx = S_CONFIG;
            end
            S_CONFIG: begin
                init = 1'b1;
                if (cfg_cnt == 2'd3) state_nx = S_SEND;
            end
            S_SEND: begin
                progress = |push_FIFO_in;
                if (all_sent)
                    state_nx = S_DRAIN;
                else if (!progress && tmo_cnt == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DRAIN: begin
                pop_FIFO_out = ~empty_out;
                progress     = |pop_FIFO_out;
                if (quiet_now && quiet_prev)
                    state_nx = S_COUNT;
                else if (!progress && tmo_cnt == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_COUNT: begin
                idx = idx_q;
                req = !cnt_gap;
                if (cnt_gap)
                    progress = 1'b1;
                else if (valid) begin
                    progress = 1'b1;
                    if (idx_q == LAST_IDX) state_nx = S_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_CONFIG;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cfg_cnt    <= '0;
            pop_q      <= '0;
            tmo_cnt    <= '0;
            quiet_prev <= 1'b0;
            cnt_gap    <= 1'b0;
            idx_q      <= '0;
            err_q      <= '0;
            ae_q       <= '0;
            af_q       <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                sent[p] <= '0;
                rcvd[p] <= '0;
                csum[p] <= '0;
            end
        end else begin
            cfg_cnt    <= (state == S_CONFIG) ? cfg_cnt + 2'd1 : 2'd0;
            pop_q      <= pop_FIFO_out;
            quiet_prev <= (state == S_DRAIN) && quiet_now;

            if (state == S_CONFIG && cfg_cnt == 2'd0) begin
                ae_q <= ae_thr;
                af_q <= af_thr;
            end

            // Stall timer: any push/pop/counter response or phase change restarts it.
            if (state != state_nx || progress ||
                !(state == S_SEND || state == S_DRAIN || state == S_COUNT))
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;

            if (run_start) begin
                cnt_gap <= 1'b0;
                idx_q   <= '0;
                err_q   <= '0;
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    sent[p] <= '0;
                    rcvd[p] <= '0;
                    csum[p] <= '0;
                end
            end

            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (push_FIFO_in[p])
                    sent[p] <= sent[p] + 1'b1;
                if (pop_q[p]) begin
                    rcvd[p] <= rcvd[p] + 1'b1;
                    csum[p] <= csum[p] + data_out[p*WORD_SIZE +: PAY_BITS];
                    if (data_out[p*WORD_SIZE + PAY_BITS +: DEST_BITS] != DEST_BITS'(p))
                        err_q[p] <= 1'b1;
                end
            end

            if (state == S_COUNT) begin
                if (!cnt_gap && valid) begin
                    if (data != rcvd[idx_q] || rcvd[idx_q] != WPP || csum[idx_q] != exp_sum[idx_q])
                        err_q[idx_q] <= 1'b1;
                    cnt_gap <= 1'b1;
                end else if (cnt_gap) begin
                    cnt_gap <= 1'b0;
                    idx_q   <= idx_q + 1'b1;
                end
            end

            if (tmo_hit)
                err_q[NUM_PORTS] <= 1'b1;
        end
    end

    assign almost_empty_threshold_input = ae_q;
    assign almost_full_threshold_input  = af_q;
    assign err_flags = {1'b0, err_q};
    assign pass      = done && (err_q == '0);

endmodule

// File: tb/tb_trans_traffic_checker.sv
// Directed bench: a transaction-layer/FIFO/counter model around the checker, with a
// scoreboard of expected pushed words per port.
module tb_trans_traffic_checker;
    localparam int unsigned N   = 4;
    localparam int unsigned WS  = 10;
    localparam int unsigned DB  = 2;
    localparam int unsigned WPP = 8;
    localparam int unsigned PS  = 3;
    localparam int unsigned CS  = 5;
    localparam int unsigned TMO = 255;
    localparam int unsigned PW  = WS - DB;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    logic start = 1'b0;
    logic [PS-1:0] ae_thr = '0, af_thr = '0;
    logic init;
    logic [PS-1:0] ae_o, af_o;
    logic [N-1:0] push;
    logic [N*WS-1:0] din;
    logic [N-1:0] af_in = '0;
    logic [N-1:0] pop;
    logic [N*WS-1:0] dout = '0;
    logic [N-1:0] empty = '1;
    logic idle = 1'b1;
    logic req;
    logic [DB-1:0] idx;
    logic [CS-1:0] cdata = '0;
    logic cvalid = 1'b0;
    logic done, pass;
    logic [N+1:0] err_flags;

    int errors = 0;
    int checks = 0;

    logic [WS-1:0] outq [N][$];
    logic [WS-1:0] exp_q [N][$];
    int unsigned pushes [N];
    int unsigned popped [N];
    bit valid_en = 1'b1, bad_idx1 = 1'b0, flip_en = 1'b0, flipped = 1'b0;

    always #5 clk = ~clk;

    trans_traffic_checker #(
        .NUM_PORTS(N), .WORD_SIZE(WS), .DEST_BITS(DB), .WORDS_PER_PORT(WPP),
        .PTR_SIZE(PS), .CNT_SIZE(CS), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset_L(reset_L), .start(start),
        .ae_thr(ae_thr), .af_thr(af_thr), .init(init),
        .almost_empty_threshold_input(ae_o), .almost_full_threshold_input(af_o),
        .push_FIFO_in(push), .dest_n_data_in(din), .almost_full_in(af_in),
        .pop_FIFO_out(pop), .data_out(dout), .empty_out(empty), .idle(idle),
        .req(req), .idx(idx), .data(cdata), .valid(cvalid),
        .done(done), .pass(pass), .err_flags(err_flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Environment: sample DUT requests at negedge, apply their effects just after the next posedge.
    always begin : env_model
        logic [N-1:0] s_push, s_pop;
        logic [N*WS-1:0] s_din;
        logic s_req, s_rst, s_start, moved;
        logic [DB-1:0] s_idx, d;
        logic [WS-1:0] w, e;
        logic [DB-1:0] ed;
        logic [PW-1:0] ep;
        @(negedge clk);
        s_push = push; s_pop = pop; s_din = din; s_req = req; s_idx = idx;
        s_rst = reset_L; s_start = start;
        if (s_rst) begin
            for (int p = 0; p < N; p++) begin
                if (s_push[p]) begin
                    check($sformatf("sb_has_word_p%0d", p), 64'(exp_q[p].size() != 0), 64'd1);
                    if (exp_q[p].size() != 0) begin
                        e = exp_q[p].pop_front();
                        check($sformatf("push_word_p%0d", p), 64'(s_din[p*WS +: WS]), 64'(e));
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        if (!s_rst) begin
            for (int p = 0; p < N; p++) begin
                outq[p].delete(); pushes[p] = 0; popped[p] = 0;
            end
            empty = '1; dout = '0; cvalid = 1'b0; cdata = '0; idle = 1'b1;
        end else begin
            if (s_start) begin
                flipped = 1'b0;
                for (int p = 0; p < N; p++) begin
                    pushes[p] = 0; popped[p] = 0; exp_q[p].delete();
                    for (int k = 0; k < WPP; k++) begin
                        ed = DB'((p + k) % N);
                        ep = PW'((p * WPP + k) % (1 << PW));
                        exp_q[p].push_back({ed, ep});
                    end
                end
            end
            moved = 1'b0;
            for (int p = 0; p < N; p++) begin
                if (s_push[p]) begin
                    w = s_din[p*WS +: WS];
                    d = w[WS-1 -: DB];
                    if (flip_en && !flipped && d == DB'(N - 1)) begin
                        d = '0;
                        flipped = 1'b1;
                    end
                    outq[d].push_back(w);
                    pushes[p]++;
                    moved = 1'b1;
                end
            end
            for (int p = 0; p < N; p++) begin
                if (s_pop[p] && outq[p].size() != 0) begin
                    dout[p*WS +: WS] = outq[p].pop_front();
                    popped[p]++;
                end
                empty[p] = (outq[p].size() == 0);
            end
            idle = !moved;
            if (cvalid)
                cvalid = 1'b0;
            else if (s_req && valid_en) begin
                cvalid = 1'b1;
                cdata = (bad_idx1 && s_idx == 1) ? CS'(7) : CS'(popped[s_idx]);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_init"}, 64'(init), 64'd0);
        check({tag, "_push"}, 64'(push), 64'd0);
        check({tag, "_din"},  64'(din), 64'd0);
        check({tag, "_pop"},  64'(pop), 64'd0);
        check({tag, "_req"},  64'(req), 64'd0);
        check({tag, "_idx"},  64'(idx), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'd0);
        check({tag, "_err"},  64'(err_flags), 64'd0);
        check({tag, "_thr"},  64'({ae_o, af_o}), 64'd0);
    endtask

    initial begin
        int n, nfull, np2, nreq;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset_L = 1'b1;
        @(negedge clk);
        check_quiet("rst");

        // Ideal run
        ae_thr = 3'd3; af_thr = 3'd6;
        pulse_start();
        @(negedge clk);
        check("cfg_init_first", 64'(init), 64'd1);
        @(posedge clk); #1 ae_thr = '0; af_thr = '0;
        check("cfg_ae_thr", 64'(ae_o), 64'd3);
        check("cfg_af_thr", 64'(af_o), 64'd6);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!init) break;
            n++;
        end
        check("cfg_len", 64'(n), 64'd4);
        nfull = 0;
        for (int i = 0; i < 40; i++) begin
            if (push == '1) nfull++;
            else if (nfull != 0) break;
            @(negedge clk);
        end
        check("send_full_cycles", 64'(nfull), 64'd8);
        wait_done(600, "ideal_done");
        check("ideal_pass", 64'(pass), 64'd1);
        check("ideal_err", 64'(err_flags), 64'd0);
        for (int p = 0; p < N; p++) begin
            check($sformatf("ideal_pushes_p%0d", p), 64'(pushes[p]), 64'(WPP));
            check($sformatf("ideal_popped_p%0d", p), 64'(popped[p]), 64'(WPP));
            check($sformatf("ideal_sb_left_p%0d", p), 64'(exp_q[p].size()), 64'd0);
        end

        // Back-pressure on port 2
        @(posedge clk); #1 af_in[2] = 1'b1;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!init) break;
        end
        np2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (push[2]) np2++;
            @(negedge clk);
        end
        check("af_port2_pushes", 64'(np2), 64'd0);
        check("af_port0_independent", 64'(pushes[0]), 64'(WPP));
        @(posedge clk); #1 af_in[2] = 1'b0;
        wait_done(600, "af_done");
        check("af_pass", 64'(pass), 64'd1);
        check("af_port2_total", 64'(pushes[2]), 64'(WPP));

        // Misrouted word: one dest-3 word lands in out FIFO 0
        flip_en = 1'b1;
        pulse_start();
        wait_done(600, "flip_done");
        check("flip_err", 64'(err_flags), 64'b001001);
        check("flip_pass", 64'(pass), 64'd0);
        flip_en = 1'b0;

        // Counter returns 7 for index 1
        bad_idx1 = 1'b1;
        pulse_start();
        wait_done(600, "cnt_done");
        check("cnt_err", 64'(err_flags), 64'b000010);
        check("cnt_pass", 64'(pass), 64'd0);
        bad_idx1 = 1'b0;

        // Counter never responds
        valid_en = 1'b0;
        pulse_start();
        nreq = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (done) break;
            if (req) nreq++;
        end
        check("tmo_done", 64'(done), 64'd1);
        check("tmo_req_cycles", 64'(nreq), 64'(TMO));
        check("tmo_err", 64'(err_flags), 64'b010000);
        check("tmo_pass", 64'(pass), 64'd0);
        valid_en = 1'b1;

        // Reset mid-SEND, then a clean restart
        pulse_start();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (push != '0) break;
        end
        check("midrst_in_send", 64'(push != '0), 64'd1);
        @(posedge clk); #1 reset_L = 1'b0;
        @(posedge clk); #1;
        check_quiet("midrst");
        reset_L = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        wait_done(600, "restart_done");
        check("restart_pass", 64'(pass), 64'd1);
        check("restart_err", 64'(err_flags), 64'd0);
        for (int p = 0; p < N; p++)
            check($sformatf("restart_popped_p%0d", p), 64'(popped[p]), 64'(WPP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
